// File: rtl/ids_pkg.sv
// Shared types and helpers for the chi-squared window detector.
package ids_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StCap,
      StDiv,
      StAcc,
      StDecide
   } state_e;

   localparam int unsigned SAT_W = 64;

   // Operands are zero-extended narrower values, so the 65-bit sum never wraps.
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input logic [SAT_W-1:0] max);
      logic [SAT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max}) ? max : sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/ids_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done follows start by exactly NUM_W cycles.
module ids_seq_div #(
   parameter int unsigned NUM_W = 32,
   parameter int unsigned DEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cancel,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [NUM_W-1:0] quot,
   output logic             done
);

   localparam int unsigned CntW = $clog2(NUM_W + 1);

   logic [DEN_W-1:0] r_rem;
   logic [DEN_W-1:0] r_den;
   logic [NUM_W-1:0] r_quo;
   logic [CntW-1:0]  r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [DEN_W-1:0] w_rem_src;
   logic [DEN_W-1:0] w_den;
   logic [NUM_W-1:0] w_quo_src;
   logic [DEN_W:0]   w_shift;
   logic [DEN_W:0]   w_diff;
   logic             w_ge;
   logic [DEN_W-1:0] w_rem_nxt;
   logic [NUM_W-1:0] w_quo_nxt;

   always_comb begin
      w_rem_src = start ? '0 : r_rem;
      w_quo_src = start ? num : r_quo;
      w_den     = start ? den : r_den;
      w_shift   = {w_rem_src, w_quo_src[NUM_W-1]};
      w_diff    = w_shift - {1'b0, w_den};
      w_ge      = (w_shift >= {1'b0, w_den});
      w_rem_nxt = w_ge ? w_diff[DEN_W-1:0] : w_shift[DEN_W-1:0];
      w_quo_nxt = {w_quo_src[NUM_W-2:0], w_ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_den  <= '0;
         r_quo  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (cancel) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (start) begin
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
         r_den  <= den;
         r_cnt  <= CntW'(NUM_W - 1);
         r_busy <= 1'b1;
         r_done <= 1'b0;
      end else if (r_busy) begin
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
         r_cnt  <= r_cnt - CntW'(1);
         r_busy <= (r_cnt != CntW'(1));
         r_done <= (r_cnt == CntW'(1));
      end else begin
         r_done <= 1'b0;
      end
   end

   assign quot = r_quo;
   assign done = r_done;

endmodule

// File: rtl/ids_window_detector.sv
// Scans E/O histogram bins, accumulates saturating sum of (O-E)^2/E and makes a
// debounced, hysteretic alarm decision once per window.
module ids_window_detector
   import ids_pkg::*;
#(
   parameter int unsigned     NUM_BINS    = 256,
   parameter int unsigned     ADDR_W      = $clog2(NUM_BINS),
   parameter int unsigned     DATA_W      = 16,
   parameter int unsigned     ACC_W       = 32,
   parameter logic [ACC_W-1:0] THRESH_HI  = ACC_W'(32'h06A9),
   parameter logic [ACC_W-1:0] THRESH_LO  = ACC_W'(32'h06A9),
   parameter bit              ALARM_ABOVE = 1'b1,
   parameter int unsigned     ALARM_COUNT = 1,
   parameter int unsigned     CLEAR_COUNT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr_out,
   input  logic [DATA_W-1:0] E_in,
   input  logic [DATA_W-1:0] O_in,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  chi_out,
   output logic              window_hit,
   output logic              alarm
);

   localparam int unsigned PW = 2 * DATA_W;

   state_e            r_state, w_state_d;
   logic [ADDR_W-1:0] r_addr;
   logic [ACC_W-1:0]  r_acc, r_term, r_chi;
   logic              r_busy, r_done, r_hit, r_alarm;
   logic [31:0]       r_hit_cnt, r_clr_cnt;
   logic              r_dec_ph, r_trig, r_clr;

   logic [DATA_W-1:0] w_absdiff;
   logic [PW-1:0]     w_d2, w_quot;
   logic              w_div_start, w_div_done, w_last, w_abort, w_trig, w_clr;
   logic [ACC_W-1:0]  w_term_sat, w_acc_sum;

   ids_seq_div #(
      .NUM_W(PW),
      .DEN_W(DATA_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (w_div_start),
      .cancel(abort),
      .num   (w_d2),
      .den   (E_in),
      .quot  (w_quot),
      .done  (w_div_done)
   );

   always_comb begin
      w_absdiff   = (O_in >= E_in) ? (O_in - E_in) : (E_in - O_in);
      w_d2        = PW'(w_absdiff) * PW'(w_absdiff);
      w_abort     = abort && (r_state != StIdle);
      w_div_start = (r_state == StCap) && (E_in != '0) && !abort;
      w_last      = (r_addr == ADDR_W'(NUM_BINS - 1));
      w_term_sat  = (|(w_quot >> ACC_W)) ? '1 : w_quot[ACC_W-1:0];
      w_acc_sum   = ACC_W'(sat_add(64'(r_acc), 64'(r_term), (64'd1 << ACC_W) - 64'd1));
      if (ALARM_ABOVE) begin
         w_trig = (r_acc > THRESH_HI);
         w_clr  = (r_acc < THRESH_LO);
      end else begin
         w_trig = (r_acc <= THRESH_HI);
         w_clr  = (r_acc > THRESH_LO);
      end
   end

   always_comb begin
      w_state_d = r_state;
      if (w_abort) begin
         w_state_d = StIdle;
      end else begin
         unique case (r_state)
            StIdle:   if (start) w_state_d = StRd;
            StRd:     w_state_d = StCap;
            StCap:    w_state_d = (E_in == '0) ? StAcc : StDiv;
            StDiv:    if (w_div_done) w_state_d = StAcc;
            StAcc:    w_state_d = w_last ? StDecide : StRd;
            StDecide: if (r_dec_ph) w_state_d = StIdle;
            default:  w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_addr    <= '0;
         r_acc     <= '0;
         r_term    <= '0;
         r_chi     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
         r_alarm   <= 1'b0;
         r_hit_cnt <= '0;
         r_clr_cnt <= '0;
         r_dec_ph  <= 1'b0;
         r_trig    <= 1'b0;
         r_clr     <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_busy  <= (w_state_d != StIdle);
         r_done  <= 1'b0;
         if (w_abort) begin
            r_dec_ph <= 1'b0;
         end else begin
            case (r_state)
               StIdle: if (start) begin
                  r_addr <= '0;
                  r_acc  <= '0;
               end
               StCap:  if (E_in == '0) r_term <= '0;
               StDiv:  if (w_div_done) r_term <= w_term_sat;
               StAcc: begin
                  r_acc <= w_acc_sum;
                  if (!w_last) r_addr <= r_addr + ADDR_W'(1);
               end
               // Compare is registered first; outputs and counters update a cycle later.
               StDecide: if (!r_dec_ph) begin
                  r_dec_ph <= 1'b1;
                  r_trig   <= w_trig;
                  r_clr    <= w_clr;
               end else begin
                  r_dec_ph <= 1'b0;
                  r_done   <= 1'b1;
                  r_chi    <= r_acc;
                  r_hit    <= r_trig;
                  if (!r_alarm) begin
                     r_clr_cnt <= '0;
                     if (!r_trig) begin
                        r_hit_cnt <= '0;
                     end else if (r_hit_cnt + 32'd1 >= ALARM_COUNT) begin
                        r_alarm   <= 1'b1;
                        r_hit_cnt <= '0;
                     end else begin
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                     end
                  end else begin
                     r_hit_cnt <= '0;
                     if (!r_clr) begin
                        r_clr_cnt <= '0;
                     end else if (r_clr_cnt + 32'd1 >= CLEAR_COUNT) begin
                        r_alarm   <= 1'b0;
                        r_clr_cnt <= '0;
                     end else begin
                        r_clr_cnt <= r_clr_cnt + 32'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign addr_out   = r_addr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign chi_out    = r_chi;
   assign window_hit = r_hit;
   assign alarm      = r_alarm;

endmodule

// File: tb/tb_ids_window_detector.sv
// Directed bench: three detector instances (main, debounce, 16-bit saturation).
module tb_ids_window_detector;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_w [3];
   logic        abort_w [3];
   logic [1:0]  addr_w  [3];
   logic [15:0] e_q     [3];
   logic [15:0] o_q     [3];
   logic        busy_w  [3];
   logic        done_w  [3];
   logic        hit_w   [3];
   logic        alarm_w [3];
   logic [31:0] chi_a, chi_b;
   logic [15:0] chi_c;
   logic [31:0] chi_w   [3];
   logic [15:0] mem_e   [3][4];
   logic [15:0] mem_o   [3][4];

   int n_tests = 0;
   int n_fail  = 0;

   always_comb begin
      chi_w[0] = chi_a;
      chi_w[1] = chi_b;
      chi_w[2] = {16'd0, chi_c};
   end

   // One-cycle-latency histogram RAMs.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         e_q[k] <= mem_e[k][addr_w[k]];
         o_q[k] <= mem_o[k][addr_w[k]];
      end
   end

   ids_window_detector #(
      .NUM_BINS(4), .DATA_W(16), .ACC_W(32), .THRESH_HI(32'd10), .THRESH_LO(32'd5),
      .ALARM_ABOVE(1'b1), .ALARM_COUNT(1), .CLEAR_COUNT(1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .start(start_w[0]), .abort(abort_w[0]), .addr_out(addr_w[0]),
      .E_in(e_q[0]), .O_in(o_q[0]), .busy(busy_w[0]), .done(done_w[0]), .chi_out(chi_a),
      .window_hit(hit_w[0]), .alarm(alarm_w[0])
   );

   ids_window_detector #(
      .NUM_BINS(4), .DATA_W(16), .ACC_W(32), .THRESH_HI(32'd10), .THRESH_LO(32'd5),
      .ALARM_ABOVE(1'b1), .ALARM_COUNT(3), .CLEAR_COUNT(2)
   ) u_dut_b (
      .clk(clk), .rst(rst), .start(start_w[1]), .abort(abort_w[1]), .addr_out(addr_w[1]),
      .E_in(e_q[1]), .O_in(o_q[1]), .busy(busy_w[1]), .done(done_w[1]), .chi_out(chi_b),
      .window_hit(hit_w[1]), .alarm(alarm_w[1])
   );

   ids_window_detector #(
      .NUM_BINS(4), .DATA_W(16), .ACC_W(16), .THRESH_HI(16'd10), .THRESH_LO(16'd5),
      .ALARM_ABOVE(1'b1), .ALARM_COUNT(1), .CLEAR_COUNT(1)
   ) u_dut_c (
      .clk(clk), .rst(rst), .start(start_w[2]), .abort(abort_w[2]), .addr_out(addr_w[2]),
      .E_in(e_q[2]), .O_in(o_q[2]), .busy(busy_w[2]), .done(done_w[2]), .chi_out(chi_c),
      .window_hit(hit_w[2]), .alarm(alarm_w[2])
   );

   task automatic load(input int k, input logic [63:0] e, input logic [63:0] o);
      for (int i = 0; i < 4; i++) begin
         mem_e[k][i] = e[63-16*i -: 16];
         mem_o[k][i] = o[63-16*i -: 16];
      end
   endtask

   task automatic pulse_start(input int k);
      @(negedge clk);
      start_w[k] = 1'b1;
      @(posedge clk);
      #1;
      start_w[k] = 1'b0;
   endtask

   // Returns posedges from the start edge until done is seen, or -1 on timeout.
   task automatic wait_done(input int k, output int cyc);
      cyc = -1;
      for (int n = 1; n <= 600; n++) begin
         @(posedge clk);
         #1;
         if (done_w[k]) begin
            cyc = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if ({busy_w[k], done_w[k], addr_w[k], chi_w[k], hit_w[k], alarm_w[k]} !== '0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: got busy=%b done=%b addr=%0d chi=%0d hit=%b alarm=%b, expected all 0",
                     k, busy_w[k], done_w[k], addr_w[k], chi_w[k], hit_w[k], alarm_w[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      load(0, 64'h0064_0064_0064_0064, 64'h006E_005A_0064_0064);
      pulse_start(0);
      n_tests++;
      if (busy_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_w[0]);
      end
      wait_done(0, cyc);
      n_tests++;
      if (cyc != 142) begin n_fail++; $display("FAIL basic_latency: got %0d expected 142", cyc); end
      n_tests++;
      if (chi_w[0] !== 32'd2) begin n_fail++; $display("FAIL basic_chi: got %0d expected 2", chi_w[0]); end
      n_tests++;
      if (hit_w[0] !== 1'b0 || alarm_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL basic_flags: got hit=%b alarm=%b expected 0 0", hit_w[0], alarm_w[0]);
      end
      n_tests++;
      if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_w[0]); end
      @(posedge clk);
      #1;
      n_tests++;
      if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done_w[0]); end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      int seen;
      pulse_start(0);
      repeat (40) @(posedge clk);
      pulse_start(0);
      wait_done(0, cyc);
      n_tests++;
      if (cyc != 101) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 101", cyc); end
      n_tests++;
      if (chi_w[0] !== 32'd2) begin n_fail++; $display("FAIL busy_start_chi: got %0d expected 2", chi_w[0]); end
      seen = 0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (done_w[0] || busy_w[0]) seen++;
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL busy_start_rescan: got %0d active cycles expected 0", seen); end
   endtask

   task automatic test_abort();
      int cyc;
      int seen;
      load(0, 64'h0001_0001_0001_0001, 64'h00C8_00C8_00C8_00C8);
      pulse_start(0);
      wait_done(0, cyc);
      n_tests++;
      if (chi_w[0] !== 32'd158404 || alarm_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL abort_setup: got chi=%0d alarm=%b expected 158404 1", chi_w[0], alarm_w[0]);
      end
      load(0, 64'h0064_0064_0064_0064, 64'h006E_005A_0064_0064);
      pulse_start(0);
      repeat (80) @(posedge clk);
      @(negedge clk);
      abort_w[0] = 1'b1;
      @(posedge clk);
      #1;
      abort_w[0] = 1'b0;
      n_tests++;
      if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b expected 0", busy_w[0]); end
      seen = 0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (done_w[0]) seen++;
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses expected 0", seen); end
      n_tests++;
      if (chi_w[0] !== 32'd158404) begin n_fail++; $display("FAIL abort_chi_held: got %0d expected 158404", chi_w[0]); end
      n_tests++;
      if (hit_w[0] !== 1'b1 || alarm_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL abort_flags_held: got hit=%b alarm=%b expected 1 1", hit_w[0], alarm_w[0]);
      end
   endtask

   task automatic test_zero_e();
      int cyc;
      load(0, 64'h0000_0064_0000_0064, 64'h0032_0064_0007_0064);
      pulse_start(0);
      wait_done(0, cyc);
      n_tests++;
      if (cyc != 78) begin n_fail++; $display("FAIL zero_e_latency: got %0d expected 78", cyc); end
      n_tests++;
      if (chi_w[0] !== 32'd0) begin n_fail++; $display("FAIL zero_e_chi: got %0d expected 0", chi_w[0]); end
      n_tests++;
      if (hit_w[0] !== 1'b0 || alarm_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL zero_e_flags: got hit=%b alarm=%b expected 0 0", hit_w[0], alarm_w[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] ov [7];
      int          chi_exp [7];
      logic        hit_exp [7];
      logic        al_exp  [7];
      int          cyc;
      ov = '{64'h00C8_00C8_00C8_00C8, 64'h00C8_00C8_00C8_00C8, 64'h00C8_00C8_00C8_00C8,
             64'h0002_0002_0001_0001, 64'h0003_0002_0002_0002, 64'h0002_0002_0001_0001,
             64'h0002_0002_0001_0001};
      chi_exp = '{158404, 158404, 158404, 2, 7, 2, 2};
      hit_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      al_exp  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int w = 0; w < 7; w++) begin
         load(1, 64'h0001_0001_0001_0001, ov[w]);
         pulse_start(1);
         wait_done(1, cyc);
         n_tests++;
         if (cyc != 142 || chi_w[1] !== 32'(chi_exp[w])) begin
            n_fail++; $display("FAIL debounce_chi[%0d]: got chi=%0d cyc=%0d expected chi=%0d cyc=142",
                               w, chi_w[1], cyc, chi_exp[w]);
         end
         n_tests++;
         if (hit_w[1] !== hit_exp[w]) begin
            n_fail++; $display("FAIL debounce_hit[%0d]: got %b expected %b", w, hit_w[1], hit_exp[w]);
         end
         n_tests++;
         if (alarm_w[1] !== al_exp[w]) begin
            n_fail++; $display("FAIL debounce_alarm[%0d]: got %b expected %b", w, alarm_w[1], al_exp[w]);
         end
      end
   endtask

   task automatic test_saturate();
      int cyc;
      load(2, 64'h0001_0001_0001_0001, 64'hFFFF_0000_0000_0000);
      pulse_start(2);
      wait_done(2, cyc);
      n_tests++;
      if (cyc != 142) begin n_fail++; $display("FAIL sat_latency: got %0d expected 142", cyc); end
      n_tests++;
      if (chi_w[2] !== 32'd65535) begin n_fail++; $display("FAIL sat_chi: got %0d expected 65535", chi_w[2]); end
      n_tests++;
      if (hit_w[2] !== 1'b1 || alarm_w[2] !== 1'b1) begin
         n_fail++; $display("FAIL sat_flags: got hit=%b alarm=%b expected 1 1", hit_w[2], alarm_w[2]);
      end
   endtask

   task automatic test_reset_mid_scan();
      load(0, 64'h0064_0064_0064_0064, 64'h006E_005A_0064_0064);
      pulse_start(0);
      repeat (60) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({busy_w[0], done_w[0], addr_w[0], chi_w[0], hit_w[0], alarm_w[0]} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_scan: got busy=%b addr=%0d chi=%0d hit=%b alarm=%b expected all 0",
                  busy_w[0], addr_w[0], chi_w[0], hit_w[0], alarm_w[0]);
      end
      n_tests++;
      if ({chi_w[2], hit_w[2], alarm_w[2]} !== '0) begin
         n_fail++; $display("FAIL rst_other_inst: got chi=%0d hit=%b alarm=%b expected 0 0 0",
                            chi_w[2], hit_w[2], alarm_w[2]);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         start_w[k] = 1'b0;
         abort_w[k] = 1'b0;
         load(k, 64'd0, 64'd0);
      end
      test_reset();
      test_basic();
      test_start_while_busy();
      test_abort();
      test_zero_e();
      test_back_to_back();
      test_saturate();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ids_window_detector.md
# ids_window_detector

Parametrised chi-squared intrusion detector. It scans NUM_BINS histogram bins of expected (E) and observed (O) counts from external RAM and accumulates Σ (O−E)²/E with a sequential divider. The result feeds a threshold decision with a selectable comparison direction, consecutive-window debouncing and hysteresis. It sits beside the histogram RAMs and produces one decision per window.

## Interface
- NUM_BINS, 256: bins per window (≥2).
- ADDR_W, $clog2(NUM_BINS): bin address width.
- DATA_W, 16: width of E/O counts.
- ACC_W, 32: chi accumulator width (≤ 2*DATA_W).
- THRESH_HI, 'h06A9: alarm-trigger threshold.
- THRESH_LO, 'h06A9: alarm-clear threshold.
- ALARM_ABOVE, 1: 1 = trigger on chi > THRESH_HI, clear on chi < THRESH_LO; 0 = trigger on chi ≤ THRESH_HI, clear on chi > THRESH_LO.
- ALARM_COUNT, 1: consecutive triggering windows needed to raise alarm.
- CLEAR_COUNT, 1: consecutive clearing windows needed to drop alarm.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a window scan; sampled only in IDLE.
- abort  in  1  synchronous scan abandon.
- addr_out  out  ADDR_W  bin address to both RAMs; read latency is 1 cycle.
- E_in  in  DATA_W  expected count at addr_out (previous cycle).
- O_in  in  DATA_W  observed count at addr_out (previous cycle).
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; chi_out, window_hit and alarm are new in this cycle.
- chi_out  out  ACC_W  last completed window's statistic.
- window_hit  out  1  last window met the trigger condition.
- alarm  out  1  debounced attack flag.

## Operation
- FSM states:
  - IDLE → RD on start.
  - RD: addr_out stable; wait for read latency.
  - CAP: register E/O and compute d² = (O−E)², 2*DATA_W bits, unsigned via |O−E|.
    - If E==0: term = 0 → ACC.
    - Else: start the divider → DIV.
  - DIV: wait for div_done.
  - ACC: acc += term.
    - If last bin → DECIDE.
    - Else addr+1 → RD.
  - DECIDE: update outputs → IDLE.
- Term = floor(d²/E), 2*DATA_W-bit quotient.
- Accumulator and term saturate at 2^ACC_W−1. No wrap.
- addr_out resets to 0 at start and holds its value in IDLE.
- Decision in DECIDE (hit = trigger condition on the final acc):
  - alarm==0:
    - hit: hit_cnt++. When hit_cnt reaches ALARM_COUNT, set alarm and zero hit_cnt.
    - No hit: hit_cnt = 0.
  - alarm==1:
    - Clear condition: clr_cnt++. When clr_cnt reaches CLEAR_COUNT, drop alarm and zero clr_cnt.
    - Otherwise: clr_cnt = 0.
  - Windows satisfying neither condition leave the counters of the inactive direction at 0.
- Legacy behaviour: ALARM_ABOVE=0, ALARM_COUNT=CLEAR_COUNT=1, THRESH_LO=THRESH_HI.
- start while busy: ignored.
- abort in any non-IDLE state: next state IDLE. No done pulse. chi_out, window_hit, alarm and counters are unchanged. The divider is cancelled. abort has priority over start.
- Reset mid-scan: everything returns to reset values immediately.

## Timing
- Reset values: busy=0, done=0, addr_out=0, chi_out=0, window_hit=0, alarm=0. All internal counters 0.
- busy is high from the cycle after start is sampled until the done cycle, exclusive.
- Per-bin cycles:
  - E≠0: 3 + 2*DATA_W (RD, CAP, DIV, ACC).
  - E==0: 3.
- Latency: done rises 2 + Σ(per-bin cycles) cycles after the start-sampling edge.
- Divider: restoring, 1 quotient bit per cycle, 2*DATA_W cycles from div_start to div_done.
- All outputs are registered. done is high for exactly one cycle. A new start is accepted the cycle after done.

## Structure
- ids_pkg:
  - state enum (IDLE, RD, CAP, DIV, ACC, DECIDE).
  - sat_add function (saturating add).
- Sub-module ids_seq_div:
  - Parameters: NUM_W=2*DATA_W, DEN_W=DATA_W.
  - Ports: clk, rst, start, cancel, num, den, quot, done.
- Top holds the FSM, accumulator and decision logic.

## Test plan
All scenarios use NUM_BINS=4, DATA_W=16, ACC_W=32, THRESH_HI=10, THRESH_LO=5, ALARM_ABOVE=1 unless stated.
- E={100,100,100,100}, O={110,90,100,100}, start → chi_out=2, window_hit=0, alarm=0; done exactly 142 cycles after the start edge.
- E={1,1,1,1}, O={200,200,200,200}, ALARM_COUNT=3, three windows → chi_out=158404 each; window_hit=1 each; alarm rises only at the third done.
- After alarm, CLEAR_COUNT=2, window sequence chi 2, 7, 2, 2 → alarm stays at 1 after windows 1–3 (chi=7 resets clr_cnt) and clears at the fourth done.
- E={0,100,0,100}, O={50,100,7,100} → chi_out=0, done 78 cycles after start; zero-E bins contribute 0.
- ACC_W=16, E={1,1,1,1}, O={65535,0,0,0} → chi_out=65535 (saturated), no wrap.
- Control events:
  - abort during DIV of bin 2 → IDLE next cycle, no done, prior outputs held.
  - start pulsed while busy → ignored.
  - rst asserted mid-scan → all outputs 0 immediately.
